// File: rtl/regfile_pipe_pkg.sv
// Shared constants and types for the register file and the stages that index it.
//   DefDataW  : default register width in bits
//   DefAddrW  : default register address width (DEPTH = 2**DefAddrW)
//   reg_idx_t : register index type for decode and ALU stages
package regfile_pipe_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNrd   = 2;

  typedef logic [DefAddrW-1:0] reg_idx_t;

  // True for the hard-wired zero register index.
  function automatic logic is_reg_zero(input reg_idx_t idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_pipe_if.sv
// Bus bundle for regfile_pipe: read ports, writeback and reservation requests, and results.
//   rd_en/rd_addr        : per-port read request, port p address at [p*ADDR_W +: ADDR_W]
//   rd_data/rd_valid/... : per-port registered results, port p data at [p*DATA_W +: DATA_W]
//   wr_en/wr_addr/wr_data: writeback (clears the pending bit)
//   rsv_en/rsv_addr      : reservation (sets the pending bit)
//   busy_any             : registered OR of the scoreboard
// master drives requests; slave (the register file) drives results.
interface regfile_pipe_if import regfile_pipe_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NRD    = DefNrd
);

  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_valid;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  rsv_en;
  logic [ADDR_W-1:0]     rsv_addr;
  logic                  busy_any;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_valid, rd_busy, busy_any
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_valid, rd_busy, busy_any
  );

endinterface

// File: rtl/regfile_rdport.sv
// One registered read port of the register file.
//   clk, rst      : clock, synchronous active-high reset
//   rd_en_i       : read request
//   rd_addr_i     : read address
//   wr_en_i/...   : same-edge writeback, used for write-through bypass
//   reg_rdata_i   : current array contents at rd_addr_i
//   busy_nxt_i    : scoreboard bit at rd_addr_i after this edge's updates
//   rd_data_o     : read data, held while no read is requested
//   rd_valid_o    : rd_data_o is fresh this cycle
//   rd_busy_o     : register was still pending a writeback when read
module regfile_rdport import regfile_pipe_pkg::*; #(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] reg_rdata_i,
  input  logic              busy_nxt_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_busy_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_q;
  logic              busy_q;

  always_comb begin
    data_d = reg_rdata_i;
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      data_d = wr_data_i;
    end
    // Zero register wins over the bypass path.
    if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= rd_en_i;
      if (rd_en_i) begin
        data_q <= data_d;
        busy_q <= busy_nxt_i;
      end
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign rd_busy_o  = busy_q;

endmodule

// File: rtl/regfile_pipe.sv
// Multi-port register file with a pending-write scoreboard.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, overrides every request on the same edge
//   bus : regfile_pipe_if slave -- NRD read ports, one writeback, one reservation, busy_any
module regfile_pipe import regfile_pipe_pkg::*; #(
  parameter int unsigned       DATA_W    = DefDataW,
  parameter int unsigned       ADDR_W    = DefAddrW,
  parameter int unsigned       NRD       = DefNrd,
  parameter int unsigned       ZERO_REG  = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  regfile_pipe_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]     regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_d, busy_q;
  logic                  busy_any_q;
  logic                  wr_ok;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_valid;
  logic [NRD-1:0]        rd_busy;

  assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Clear on writeback first, then set on reservation: a same-edge reservation is a newer
  // pending write and must survive the completing one.
  always_comb begin
    busy_d = busy_q;
    if (bus.wr_en) begin
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (bus.rsv_en) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VAL;
      end
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs_q[bus.wr_addr] <= bus.wr_data;
      end
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rdport
    logic [ADDR_W-1:0] addr;
    assign addr = bus.rd_addr[p*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .clk         (clk),
      .rst         (rst),
      .rd_en_i     (bus.rd_en[p]),
      .rd_addr_i   (addr),
      .wr_en_i     (bus.wr_en),
      .wr_addr_i   (bus.wr_addr),
      .wr_data_i   (bus.wr_data),
      .reg_rdata_i (regs_q[addr]),
      .busy_nxt_i  (busy_d[addr]),
      .rd_data_o   (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid_o  (rd_valid[p]),
      .rd_busy_o   (rd_busy[p])
    );
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_busy  = rd_busy;
  assign bus.busy_any = busy_any_q;

endmodule

// File: tb/tb_regfile_pipe.sv
// Self-checking bench for regfile_pipe: directed scenarios plus randomized traffic
// compared against an array/scoreboard reference model.
module tb_regfile_pipe;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NP    = 2;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NP)) bus ();

  regfile_pipe #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NRD       (NP),
    .ZERO_REG  (1),
    .RESET_VAL ('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy [DEPTH];
  logic [DW-1:0] e_data [NP];
  bit            e_valid [NP];
  bit            e_rbusy [NP];
  bit            e_any;

  task automatic idle();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_en[p]             = 1'b1;
    bus.rd_addr[p*AW +: AW]  = AW'(a);
  endtask

  task automatic set_wr(input int a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  task automatic set_rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  function automatic logic [DW-1:0] got_data(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  // Advance the model with the inputs present before the edge, then clock and settle.
  task automatic tick();
    bit nb [DEPTH];
    int a;
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
      for (int p = 0; p < int'(NP); p++) begin
        e_data[p]  = '0;
        e_valid[p] = 1'b0;
        e_rbusy[p] = 1'b0;
      end
      e_any = 1'b0;
    end else begin
      nb = m_busy;
      if (bus.wr_en) nb[bus.wr_addr] = 1'b0;
      if (bus.rsv_en) nb[bus.rsv_addr] = 1'b1;
      nb[0] = 1'b0;
      for (int p = 0; p < int'(NP); p++) begin
        e_valid[p] = bus.rd_en[p];
        if (bus.rd_en[p]) begin
          a = int'(bus.rd_addr[p*AW +: AW]);
          if (a == 0) e_data[p] = '0;
          else if (bus.wr_en && int'(bus.wr_addr) == a) e_data[p] = bus.wr_data;
          else e_data[p] = m_reg[a];
          e_rbusy[p] = nb[a];
        end
      end
      if (bus.wr_en && bus.wr_addr != '0) m_reg[bus.wr_addr] = bus.wr_data;
      m_busy = nb;
      e_any  = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) e_any = e_any | nb[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_wr(4, 32'h1111_2222);
    set_rd(0, 4);
    tick();
    tick();
    rst = 1'b0;
    n_run++;
    if (bus.rd_data !== '0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data);
    end
    n_run++;
    if (bus.rd_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset_rd_valid: got %b want 00", bus.rd_valid);
    end
    n_run++;
    if (bus.rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_rd_busy: got %b want 00", bus.rd_busy);
    end
    n_run++;
    if (bus.busy_any !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_any: got %b want 0", bus.busy_any);
    end
    idle();
    set_rd(0, 7);
    tick();
    n_run++;
    if (got_data(0) !== 32'h0 || bus.rd_valid !== 2'b01 || bus.rd_busy[0] !== 1'b0
        || bus.busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL read_after_reset: got data=%h valid=%b busy=%b any=%b want 0/01/0/0",
               got_data(0), bus.rd_valid, bus.rd_busy[0], bus.busy_any);
    end
  endtask

  task automatic test_bypass();
    idle();
    set_wr(3, 32'hDEAD_BEEF);
    set_rd(0, 3);
    set_rd(1, 3);
    tick();
    n_run++;
    if (got_data(0) !== 32'hDEAD_BEEF || got_data(1) !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_both_ports: got %h/%h want deadbeef", got_data(0), got_data(1));
    end
    n_run++;
    if (bus.rd_valid !== 2'b11) begin
      n_fail++; $display("FAIL bypass_valid: got %b want 11", bus.rd_valid);
    end
    idle();
    tick();
    n_run++;
    if (bus.rd_valid !== 2'b00 || got_data(0) !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL idle_hold: got valid=%b data=%h want 00/deadbeef", bus.rd_valid,
               got_data(0));
    end
  endtask

  task automatic test_zero_reg();
    idle();
    set_wr(0, 32'h1234_5678);
    set_rd(0, 0);
    set_rd(1, 0);
    tick();
    n_run++;
    if (got_data(0) !== 32'h0 || got_data(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_bypass: got %h/%h want 0", got_data(0), got_data(1));
    end
    idle();
    set_rd(0, 0);
    tick();
    n_run++;
    if (got_data(0) !== 32'h0) begin
      n_fail++; $display("FAIL zero_read: got %h want 0", got_data(0));
    end
    idle();
    set_rsv(0);
    set_rd(1, 0);
    tick();
    n_run++;
    if (bus.busy_any !== 1'b0 || bus.rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_rsv: got any=%b rd_busy=%b want 0/0", bus.busy_any, bus.rd_busy[1]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rsv(5);
    tick();
    n_run++;
    if (bus.busy_any !== 1'b1) begin
      n_fail++; $display("FAIL rsv_busy_any: got %b want 1", bus.busy_any);
    end
    idle();
    set_rd(0, 5);
    tick();
    n_run++;
    if (bus.rd_busy[0] !== 1'b1 || bus.busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL rsv_read: got rd_busy=%b any=%b want 1/1", bus.rd_busy[0], bus.busy_any);
    end
    idle();
    set_wr(5, 32'hA5);
    set_rd(0, 5);
    tick();
    n_run++;
    if (got_data(0) !== 32'hA5 || bus.rd_busy[0] !== 1'b0 || bus.busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL writeback_read: got data=%h rd_busy=%b any=%b want a5/0/0",
               got_data(0), bus.rd_busy[0], bus.busy_any);
    end
    // Double reservation is not counted: one writeback clears it.
    idle(); set_rsv(6); tick();
    idle(); set_rsv(6); set_rd(1, 8); set_rsv(6); tick();
    idle(); set_wr(6, 32'h66); tick();
    n_run++;
    if (bus.busy_any !== 1'b0) begin
      n_fail++; $display("FAIL double_rsv: got any=%b want 0", bus.busy_any);
    end
    // Reservation and read on the same edge: the read sees the new bit.
    idle(); set_rsv(8); set_rd(1, 8); tick();
    n_run++;
    if (bus.rd_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL rsv_same_edge_read: got %b want 1", bus.rd_busy[1]);
    end
    idle(); set_wr(8, 32'h88); tick();
  endtask

  task automatic test_rsv_write_same();
    idle();
    set_wr(10, 32'h1010);
    tick();
    n_run++;
    if (bus.busy_any !== 1'b0) begin
      n_fail++; $display("FAIL write_not_busy: got any=%b want 0", bus.busy_any);
    end
    idle();
    set_rsv(9);
    set_wr(9, 32'h9999_0009);
    tick();
    n_run++;
    if (bus.busy_any !== 1'b1) begin
      n_fail++; $display("FAIL rsv_wr_same_any: got %b want 1", bus.busy_any);
    end
    idle();
    set_rd(0, 9);
    tick();
    n_run++;
    if (bus.rd_busy[0] !== 1'b1 || got_data(0) !== 32'h9999_0009) begin
      n_fail++;
      $display("FAIL rsv_wr_same_read: got busy=%b data=%h want 1/99990009", bus.rd_busy[0],
               got_data(0));
    end
    idle(); set_wr(9, 32'h9); tick();
  endtask

  task automatic test_reset_priority();
    idle();
    set_wr(4, 32'hCAFE_0004);
    tick();
    rst = 1'b1;
    set_wr(4, 32'h1111_2222);
    set_rd(0, 4);
    set_rsv(4);
    tick();
    rst = 1'b0;
    n_run++;
    if (bus.rd_valid !== 2'b00) begin
      n_fail++; $display("FAIL rst_prio_valid: got %b want 00", bus.rd_valid);
    end
    idle();
    set_rd(0, 4);
    tick();
    n_run++;
    if (got_data(0) !== 32'h0 || bus.busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_prio_read: got data=%h any=%b want 0/0", got_data(0), bus.busy_any);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      // Narrow address range half the time to provoke collisions and bypasses.
      for (int p = 0; p < int'(NP); p++) begin
        if ($urandom_range(0, 2) != 0) set_rd(p, int'($urandom_range(0, (n % 2) ? 7 : 31)));
      end
      if ($urandom_range(0, 1) != 0) set_wr(int'($urandom_range(0, (n % 2) ? 7 : 31)), $urandom);
      if ($urandom_range(0, 2) == 0) set_rsv(int'($urandom_range(0, (n % 2) ? 7 : 31)));
      tick();
      for (int p = 0; p < int'(NP); p++) begin
        n_run++;
        if (bus.rd_valid[p] !== e_valid[p]) begin
          n_fail++; $display("FAIL rand_valid%0d @%0d: got %b want %b", p, n, bus.rd_valid[p],
                             e_valid[p]);
        end
        n_run++;
        if (got_data(p) !== e_data[p]) begin
          n_fail++; $display("FAIL rand_data%0d @%0d: got %h want %h", p, n, got_data(p),
                             e_data[p]);
        end
        if (e_valid[p]) begin
          n_run++;
          if (bus.rd_busy[p] !== e_rbusy[p]) begin
            n_fail++; $display("FAIL rand_busy%0d @%0d: got %b want %b", p, n, bus.rd_busy[p],
                               e_rbusy[p]);
          end
        end
      end
      n_run++;
      if (bus.busy_any !== e_any) begin
        n_fail++; $display("FAIL rand_busy_any @%0d: got %b want %b", n, bus.busy_any, e_any);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_rsv_write_same();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_pipe.md
REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 Parameter DATA_W, default 32: register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2: number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 always reads zero and ignores writes and reservations.
REQ-005 Parameter RESET_VAL, default 0: value loaded into every register on reset.
REQ-006 clk  in  1: single clock; all state updates on its rising edge.
REQ-007 rst  in  1: synchronous reset, active-high.
REQ-008 rd_en  in  NRD: per-port read request.
REQ-009 rd_addr  in  NRD*ADDR_W: per-port read address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 rd_data  out  NRD*DATA_W: per-port registered read data.
REQ-011 rd_valid  out  NRD: per-port flag; rd_data is a fresh result this cycle.
REQ-012 rd_busy  out  NRD: per-port flag; register read was still pending a writeback.
REQ-013 wr_en  in  1: writeback request.
REQ-014 wr_addr  in  ADDR_W: writeback address.
REQ-015 wr_data  in  DATA_W: writeback data.
REQ-016 rsv_en  in  1: reservation request; marks a register as having a pending write.
REQ-017 rsv_addr  in  ADDR_W: reservation address.
REQ-018 busy_any  out  1: registered OR of all scoreboard bits.

Function
REQ-019 The block SHALL hold DEPTH registers of DATA_W bits and a DEPTH-bit scoreboard busy[].
REQ-020 A write SHALL update reg[wr_addr] with wr_data on the edge where wr_en=1.
REQ-021 A read SHALL have 1-cycle latency: rd_en[p]=1 at edge N presents data on rd_data[p] after edge N, with rd_valid[p]=1 for exactly that cycle.
REQ-022 When rd_en[p]=0, rd_data[p] SHALL hold its last value and rd_valid[p] SHALL be 0.
REQ-023 A read and write to the same address on the same edge SHALL return wr_data (write-through bypass), on every port independently.
REQ-024 With ZERO_REG=1, a read of address 0 SHALL return 0 even when bypassed, and rd_busy SHALL be 0.
REQ-025 rsv_en=1 SHALL set busy[rsv_addr]; wr_en=1 SHALL clear busy[wr_addr].
REQ-026 A reservation and a write to the same address on the same edge SHALL leave busy set; the new pending write overrides the completed one.
REQ-027 A reservation of an already-busy register SHALL leave it busy; no counting.
REQ-028 A write to a non-busy register SHALL be legal and leave busy clear.
REQ-029 rd_busy[p] SHALL be registered with rd_data[p] and SHALL equal busy[addr] as updated by that same edge per REQ-025/026.
REQ-030 busy_any SHALL reflect the scoreboard after the current edge's updates.
REQ-031 Multiple ports reading the same address SHALL receive identical results.

Reset
REQ-032 On rst=1 at a rising edge, every register SHALL load RESET_VAL, register 0 SHALL load 0 when ZERO_REG=1, and all busy bits SHALL clear.
REQ-033 On reset, rd_data SHALL be 0, and rd_valid, rd_busy and busy_any SHALL be 0.
REQ-034 Reset SHALL take priority over write, reservation and read on the same edge; those requests are discarded.

Structure
REQ-035 Shared package SHALL hold the default DATA_W and ADDR_W constants and a register-index typedef for use by decode and ALU stages.
REQ-036 One sub-module, regfile_rdport, SHALL implement a single read port (address compare, bypass, zero-forcing, output registers) and SHALL be instantiated NRD times by a generate loop.

Verification
REQ-037 Reset then read addr 7 on port 0 -> next cycle rd_data=0, rd_valid=1, rd_busy=0, busy_any=0.
REQ-038 Write 0xDEADBEEF to addr 3 while port 0 and port 1 both read addr 3 on the same edge -> both return 0xDEADBEEF one cycle later.
REQ-039 Write 0x12345678 to addr 0, then read addr 0 -> 0; reserve addr 0 -> busy_any stays 0.
REQ-040 Reserve addr 5, then read addr 5 -> rd_busy=1, busy_any=1; write 0xA5 to addr 5 while reading it -> rd_data=0xA5, rd_busy=0, busy_any=0.
REQ-041 Reserve and write addr 9 on the same edge -> busy[9] stays 1; a later read of addr 9 shows rd_busy=1 and the written data.
REQ-042 Assert rst while writing addr 4 and reading addr 4 -> rd_valid=0, and a following read of addr 4 returns RESET_VAL.
